// File: rtl/param_shift_unit.sv
// Multi-mode shift register: programmed multi-bit shifts (one bit per cycle)
// with start/done handshake, plus single-step shifting while idle.
module param_shift_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             shift_enable,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] amt_q;
  logic [CNT_W-1:0] amt_start;
  logic [WIDTH-1:0] sh_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       m);
    case (m)
      2'b01:   return {1'b0, v[WIDTH-1:1]};
      2'b10:   return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {v[WIDTH-2:0], 1'b0};
    endcase
  endfunction

  // Normalize also stops as soon as the MSB is set.
  function automatic logic term_fn(input logic [WIDTH-1:0] v,
                                   input logic [CNT_W-1:0] c,
                                   input logic [1:0]       m,
                                   input logic [CNT_W-1:0] a);
    return (c == a) || ((m == 2'b11) && v[WIDTH-1]);
  endfunction

  assign amt_start = (amount > WIDTH_C) ? WIDTH_C : amount;
  assign sh_nxt    = shift_fn(out, mode_q);
  assign cnt_nxt   = count + CNT_W'(1);
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      count  <= '0;
      mode_q <= 2'b00;
      amt_q  <= '0;
    end else if (ld) begin
      out   <= in;
      count <= '0;
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            amt_q  <= amt_start;
            count  <= '0;
            state  <= term_fn(out, CNT_W'(0), mode, amt_start) ? DONE : SHIFT;
          end else if (shift_enable) begin
            out <= shift_fn(out, mode);
          end
        end
        SHIFT: begin
          out   <= sh_nxt;
          count <= cnt_nxt;
          if (term_fn(sh_nxt, cnt_nxt, mode_q, amt_q)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_shift_unit.sv
// Scoreboard bench for param_shift_unit: directed operations push expected
// results; a negedge monitor checks every done pulse against the queue.
module tb_param_shift_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld = 1'b0;
  logic [15:0] in_d = '0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  amount = '0;
  logic        shift_enable = 1'b0;
  logic [15:0] out;
  logic [4:0]  count;
  logic        busy;
  logic        done;

  param_shift_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .ld(ld), .in(in_d), .start(start), .mode(mode),
    .amount(amount), .shift_enable(shift_enable), .out(out), .count(count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic [4:0]  c;
    int          n;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 with no operation expected (out=0x%0h)", out);
        end else begin
          e = q.pop_front();
          chk("done_out", 32'(out), 32'(e.o));
          chk("done_count", 32'(count), 32'(e.c));
          chk("done_latency", 32'(cyc - e.t), 32'(e.n));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.n));
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [15:0] v, input logic [1:0] m, input logic [4:0] a,
                       input logic [15:0] eo, input logic [4:0] ec, input int n);
    exp_t e;
    @(negedge clk);
    ld = 1'b1; in_d = v;
    @(negedge clk);
    ld = 1'b0; start = 1'b1; mode = m; amount = a;
    e.o = eo; e.c = ec; e.n = n; e.t = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; mode = ~m; amount = 5'd1;
    wait_drain();
  endtask

  task automatic start_then_3_shifts(input logic [15:0] v);
    @(negedge clk);
    ld = 1'b1; in_d = v;
    @(negedge clk);
    ld = 1'b0; start = 1'b1; mode = 2'b00; amount = 5'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'hEEEA, 2'b00, 5'd3,  16'h7750, 5'd3,  3);
    do_op(16'hF0F0, 2'b10, 5'd4,  16'hFF0F, 5'd4,  4);
    do_op(16'hF0F0, 2'b01, 5'd4,  16'h0F0F, 5'd4,  4);
    do_op(16'h00A0, 2'b11, 5'd16, 16'hA000, 5'd8,  8);
    do_op(16'hFFFF, 2'b01, 5'd20, 16'h0000, 5'd16, 16);
    do_op(16'h8001, 2'b11, 5'd5,  16'h8001, 5'd0,  0);
    do_op(16'h1234, 2'b00, 5'd0,  16'h1234, 5'd0,  0);
    do_op(16'h0000, 2'b11, 5'd5,  16'h0000, 5'd5,  5);

    // Abort with ld after 3 shifts
    start_then_3_shifts(16'h1234);
    chk("abort_pre_out", 32'(out), 32'h91A0);
    chk("abort_pre_count", 32'(count), 32'd3);
    ld = 1'b1; in_d = 16'hBEEF;
    @(negedge clk);
    ld = 1'b0;
    chk("abort_out", 32'(out), 32'hBEEF);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_hold_out", 32'(out), 32'hBEEF);

    // Abort with asynchronous reset mid-shift
    start_then_3_shifts(16'h1234);
    #1 rst = 1'b1;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_idle_out", 32'(out), 32'd0);

    // Idle single-step shifts
    ld = 1'b1; in_d = 16'hEEEA;
    @(negedge clk);
    ld = 1'b0; shift_enable = 1'b1; mode = 2'b00;
    @(negedge clk);
    chk("se1_out", 32'(out), 32'hDDD4);
    @(negedge clk);
    chk("se2_out", 32'(out), 32'hBBA8);
    @(negedge clk);
    shift_enable = 1'b0;
    chk("se3_out", 32'(out), 32'h7750);
    chk("se_count", 32'(count), 32'd0);
    ld = 1'b1; in_d = 16'h8000;
    @(negedge clk);
    ld = 1'b0; shift_enable = 1'b1; mode = 2'b10;
    @(negedge clk);
    shift_enable = 1'b0;
    chk("se_arith_out", 32'(out), 32'hC000);

    // ld + start + shift_enable together: load only
    ld = 1'b1; in_d = 16'h1111;
    @(negedge clk);
    in_d = 16'h5555; start = 1'b1; shift_enable = 1'b1; mode = 2'b00; amount = 5'd2;
    @(negedge clk);
    ld = 1'b0; start = 1'b0; shift_enable = 1'b0;
    chk("combo_out", 32'(out), 32'h5555);
    chk("combo_count", 32'(count), 32'd0);
    chk("combo_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("combo_hold_out", 32'(out), 32'h5555);

    // Shift after a programmed op keeps count
    do_op(16'h0001, 2'b00, 5'd2, 16'h0004, 5'd2, 2);
    shift_enable = 1'b1; mode = 2'b00;
    @(negedge clk);
    shift_enable = 1'b0;
    chk("se_post_out", 32'(out), 32'h0008);
    chk("se_post_count", 32'(count), 32'd2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
